// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-port round-robin arbiter in front of a single-port data
//            memory. Bursting is enabled by defining DMEM_ARB_BURST_EN.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_wr,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_wr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

`ifdef DMEM_ARB_BURST_EN
    localparam bit C_BURST_EN = 1'b1;
    localparam logic [3:0] C_LAST = 4'(MAX_BURST - 1);
    logic [3:0] cnt_q, cnt_d;
`else
    localparam bit C_BURST_EN = 1'b0;
`endif

    if (MAX_BURST < 2 || MAX_BURST > 15) begin : g_param_chk
        $error("dmem_arbiter: MAX_BURST must be in 2..15");
    end

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              p0_rvalid_q, p0_rvalid_d, p1_rvalid_q, p1_rvalid_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d, p1_rdata_q, p1_rdata_d;

    logic   w_acc0, w_acc1, w_acc, w_wr;
    logic   w_mine_req, w_other_req, w_burst_end;
    state_t w_other_st;

    assign p0_gnt    = (state_q == OWN0);
    assign p1_gnt    = (state_q == OWN1);
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

    // Memory side: reset suppresses any access in the reset cycle itself.
    always_comb begin
        w_acc0    = (state_q == OWN0) && p0_req && !rst;
        w_acc1    = (state_q == OWN1) && p1_req && !rst;
        w_acc     = w_acc0 || w_acc1;
        w_wr      = w_acc0 ? p0_wr : p1_wr;
        mem_rd    = w_acc && !w_wr;
        mem_wr    = w_acc && w_wr;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_acc0) begin
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (w_acc1) begin
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
        p0_rvalid_d = w_acc0 && !p0_wr;
        p1_rvalid_d = w_acc1 && !p1_wr;
        p0_rdata_d  = p0_rvalid_d ? mem_rdata : p0_rdata_q;
        p1_rdata_d  = p1_rvalid_d ? mem_rdata : p1_rdata_q;
    end

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        w_mine_req  = (state_q == OWN0) ? p0_req : p1_req;
        w_other_req = (state_q == OWN0) ? p1_req : p0_req;
        w_other_st  = (state_q == OWN0) ? OWN1 : OWN0;
`ifdef DMEM_ARB_BURST_EN
        w_burst_end = (cnt_q == C_LAST);
`else
        w_burst_end = 1'b1;
`endif
        case (state_q)
            IDLE: begin
                if (p0_req && (!p1_req || last_q)) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (p1_req) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (w_mine_req && !w_burst_end) begin
                    state_d = state_q;
                end else if (w_other_req) begin
                    state_d = w_other_st;
                    last_d  = (w_other_st == OWN1);
                end else if (!(w_mine_req && C_BURST_EN)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef DMEM_ARB_BURST_EN
        // A full burst with nobody waiting restarts the count without a bubble.
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (w_acc) begin
            cnt_d = w_burst_end ? 4'd0 : cnt_q + 4'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
`ifdef DMEM_ARB_BURST_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
`ifdef DMEM_ARB_BURST_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule
`default_nettype wire
